// File: rtl/rwl_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rwl_ctrl_pkg
// Shared types and constants for the read word-line controller:
//   state_e   - controller FSM states (idle / drive word line / capture)
//   owner_e   - which requester owns the read in flight
//   DEF_*     - default address and data widths
//   arb_pick  - two-requester arbitration helper
// -----------------------------------------------------------------------------
package rwl_ctrl_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 3;
    localparam int unsigned DEF_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StDrive   = 2'd1,
        StCapture = 2'd2
    } state_e;

    typedef enum logic {
        OwnerReq0 = 1'b0,
        OwnerReq1 = 1'b1
    } owner_e;

    // last_srv only matters on a tie; with rr_en low requester 0 always wins ties.
    function automatic owner_e arb_pick(input logic   req0,
                                        input logic   req1,
                                        input owner_e last_srv,
                                        input logic   rr_en);
        owner_e w;
        if (req0 && req1) begin
            w = (rr_en && (last_srv == OwnerReq0)) ? OwnerReq1 : OwnerReq0;
        end else if (req1) begin
            w = OwnerReq1;
        end else begin
            w = OwnerReq0;
        end
        return w;
    endfunction

endpackage

// File: rtl/rwl_read_ctrl_if.sv
// -----------------------------------------------------------------------------
// rwl_read_ctrl_if
// Requester-side bus of the read word-line controller.
//   req0/addr0, req1/addr1 : read requests (held until grant) and addresses
//   gnt0/gnt1              : one-cycle grant pulses
//   rdata                  : registered read data shared by both requesters
//   rvalid0/rvalid1        : one-cycle read-data-valid pulses
//   busy                   : controller not idle
// Modports: master = requester side, slave = controller side.
// -----------------------------------------------------------------------------
interface rwl_read_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = rwl_ctrl_pkg::DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = rwl_ctrl_pkg::DEF_DATA_WIDTH
) ();

    logic                  req0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic                  req1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic                  gnt0;
    logic                  gnt1;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid0;
    logic                  rvalid1;
    logic                  busy;

    modport master (
        output req0, addr0, req1, addr1,
        input  gnt0, gnt1, rdata, rvalid0, rvalid1, busy
    );

    modport slave (
        input  req0, addr0, req1, addr1,
        output gnt0, gnt1, rdata, rvalid0, rvalid1, busy
    );

endinterface

// File: rtl/rwl_decoder.sv
// -----------------------------------------------------------------------------
// rwl_decoder
// Address to one-hot word-line decode with an enable that forces all lines low.
//   en   in  1                gate; 0 -> dec = 0
//   addr in  ADDR_WIDTH       word address
//   dec  out 2**ADDR_WIDTH    one-hot word lines
// -----------------------------------------------------------------------------
module rwl_decoder #(
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                       en,
    input  logic [ADDR_WIDTH-1:0]      addr,
    output logic [2**ADDR_WIDTH-1:0]   dec
);

    always_comb begin
        dec = '0;
        if (en) begin
            dec[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/rwl_read_ctrl.sv
// -----------------------------------------------------------------------------
// rwl_read_ctrl
// Arbitrates two read requesters onto a word-line array. A read drives one
// word line for RWL_PULSE cycles, registers the bit lines on the closing edge
// of the last pulse cycle, then spends one precharge cycle (RWL low) while
// signalling read-data-valid to the owner.
//   clk  in   1               clock, rising edge
//   rst  in   1               asynchronous active-high reset
//   bus  slave modport        requester handshake (req/addr/gnt/rdata/rvalid/busy)
//   rwl  out  2**ADDR_WIDTH   one-hot read word lines
//   rbl  in   DATA_WIDTH      read bit lines
// Parameters: ADDR_WIDTH, DATA_WIDTH, RWL_PULSE (1..15).
// Build option: define RWL_RR_ARB_EN for round-robin tie-breaking; otherwise
// requester 0 has fixed priority.
// -----------------------------------------------------------------------------
module rwl_read_ctrl
    import rwl_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned RWL_PULSE  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    rwl_read_ctrl_if.slave           bus,
    output logic [2**ADDR_WIDTH-1:0] rwl,
    input  logic [DATA_WIDTH-1:0]    rbl
);

    state_e                state_q, state_d;
    owner_e                owner_q, owner_d;
    owner_e                winner;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  drive_en;
    logic                  last_drive;
    logic                  gnt0, gnt1, rvalid0, rvalid1;

    assign last_drive = (cnt_q == 4'(RWL_PULSE - 1));

`ifdef RWL_RR_ARB_EN
    owner_e last_q, last_d;

    assign winner = arb_pick(bus.req0, bus.req1, last_q, 1'b1);

    always_comb begin
        last_d = last_q;
        if ((state_q == StIdle) && (bus.req0 || bus.req1)) begin
            last_d = winner;
        end
    end

    // Reset value makes requester 0 win the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= OwnerReq1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign winner = arb_pick(bus.req0, bus.req1, OwnerReq1, 1'b0);
`endif

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        drive_en = 1'b0;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        rvalid0  = 1'b0;
        rvalid1  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req0 || bus.req1) begin
                    state_d = StDrive;
                    owner_d = winner;
                    addr_d  = (winner == OwnerReq1) ? bus.addr1 : bus.addr0;
                    cnt_d   = '0;
                end
            end
            StDrive: begin
                drive_en = 1'b1;
                // Grant only in the first pulse cycle.
                if (cnt_q == '0) begin
                    gnt0 = (owner_q == OwnerReq0);
                    gnt1 = (owner_q == OwnerReq1);
                end
                cnt_d = cnt_q + 4'd1;
                if (last_drive) begin
                    rdata_d = rbl;
                    state_d = StCapture;
                end
            end
            StCapture: begin
                rvalid0 = (owner_q == OwnerReq0);
                rvalid1 = (owner_q == OwnerReq1);
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= OwnerReq0;
            addr_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    rwl_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_decoder (
        .en   (drive_en),
        .addr (addr_q),
        .dec  (rwl)
    );

    assign bus.gnt0    = gnt0;
    assign bus.gnt1    = gnt1;
    assign bus.rvalid0 = rvalid0;
    assign bus.rvalid1 = rvalid1;
    assign bus.rdata   = rdata_q;
    assign bus.busy    = (state_q != StIdle);

endmodule
